// File: rtl/multi_wrapper_controller.sv
// Job sequencer: loads operands, runs an engine ITER times, and writes each
// result with an optional acknowledge handshake, a WAIT timeout and an abort.
module multi_wrapper_controller #(
    parameter int ITER     = 4,
    parameter int CNT_W    = 2,
    parameter int ACK_MODE = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_start,
    input  logic             engDone,
    input  logic             wrAck,
    input  logic             abort,
    output logic             wDone,
    output logic             busy,
    output logic             Ldx,
    output logic             Ldu,
    output logic             engStart,
    output logic             shiftL,
    output logic             wr_req,
    output logic             err,
    output logic [CNT_W-1:0] iterIdx
);

    localparam int TO_W = 8;
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER - 1);
    localparam bit               TO_EN     = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] iter_r, iter_s;
    logic [TO_W-1:0]  to_cnt_r, to_cnt_s;
    logic             advance_s;

    assign advance_s = (ACK_MODE == 0) ? 1'b1 : wrAck;
    // The write pulse must land in the acknowledge cycle itself, so it is the
    // only output qualified by live inputs.
    assign shiftL    = wr_req & advance_s & ~abort;
    assign iterIdx   = iter_r;

    // Next-state, run index and timeout counter; abort outranks everything.
    always_comb begin
        state_s  = state_r;
        iter_s   = iter_r;
        to_cnt_s = to_cnt_r;
        if (abort && (state_r != S_IDLE)) begin
            state_s  = S_IDLE;
            iter_s   = {CNT_W{1'b0}};
            to_cnt_s = {TO_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (w_start) begin
                        state_s = S_INIT;
                        iter_s  = {CNT_W{1'b0}};
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_INIT: begin
                    iter_s = {CNT_W{1'b0}};
                    if (w_start) begin
                        state_s = S_INIT;
                    end else begin
                        state_s = S_START;
                    end
                end
                S_START: begin
                    to_cnt_s = {TO_W{1'b0}};
                    state_s  = S_WAIT;
                end
                S_WAIT: begin
                    if (engDone) begin
                        state_s = S_WRITE;
                    end else if (TO_EN && (to_cnt_r == TO_LAST)) begin
                        state_s = S_ERR;
                    end else begin
                        to_cnt_s = to_cnt_r + TO_W'(1'b1);
                    end
                end
                S_WRITE: begin
                    if (!advance_s) begin
                        state_s = S_WRITE;
                    end else if (iter_r == ITER_LAST) begin
                        state_s = S_IDLE;
                    end else begin
                        iter_s  = iter_r + CNT_W'(1'b1);
                        state_s = S_START;
                    end
                end
                S_ERR: begin
                    state_s = S_ERR;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State registers plus Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            iter_r   <= {CNT_W{1'b0}};
            to_cnt_r <= {TO_W{1'b0}};
            wDone    <= 1'b1;
            busy     <= 1'b0;
            Ldx      <= 1'b0;
            Ldu      <= 1'b0;
            engStart <= 1'b0;
            wr_req   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_r  <= state_s;
            iter_r   <= iter_s;
            to_cnt_r <= to_cnt_s;
            wDone    <= (state_s == S_IDLE);
            busy     <= (state_s == S_INIT) || (state_s == S_START) ||
                        (state_s == S_WAIT) || (state_s == S_WRITE);
            Ldx      <= (state_s == S_INIT);
            Ldu      <= (state_s == S_INIT);
            engStart <= (state_s == S_START);
            wr_req   <= (state_s == S_WRITE);
            err      <= (state_s == S_ERR);
        end
    end

endmodule

// File: tb/tb_multi_wrapper_controller.sv
// Bench for multi_wrapper_controller: three parameterisations checked every
// cycle against a job-level model, plus a vector table and directed sequences.
module tb_multi_wrapper_controller;

    logic       clk;
    logic       rst;
    logic [2:0] ws, ed, ack, ab;
    logic [2:0] wdone, busy, ldx, ldu, es, sh, wr, er;
    logic [5:0] idx_v;

    int nchk = 0;
    int nerr = 0;

    localparam int P_IDLE = 0, P_INIT = 1, P_START = 2, P_WAIT = 3, P_WRITE = 4, P_ERR = 5;
    localparam logic [9:0] RST_PAT = 10'b1000000000;
    localparam logic [6:0] E_IDLE = 7'b1000000, E_INIT = 7'b0110000, E_START = 7'b0101000,
                           E_WAIT = 7'b0100000, E_WRTS = 7'b0100110, E_ERR = 7'b0000001;

    int ph [3];
    int run [3];
    int waited [3];
    logic [9:0] last_obs [3];

    typedef struct {
        logic ws;
        logic ed;
        logic ab;
        logic [6:0] exp;
    } vec_t;
    vec_t tbl[$];

    multi_wrapper_controller #(.ITER(4), .CNT_W(2), .ACK_MODE(0), .TIMEOUT(10)) dut0 (
        .clk(clk), .rst(rst), .w_start(ws[0]), .engDone(ed[0]), .wrAck(ack[0]), .abort(ab[0]),
        .wDone(wdone[0]), .busy(busy[0]), .Ldx(ldx[0]), .Ldu(ldu[0]), .engStart(es[0]),
        .shiftL(sh[0]), .wr_req(wr[0]), .err(er[0]), .iterIdx(idx_v[1:0]));
    multi_wrapper_controller #(.ITER(4), .CNT_W(2), .ACK_MODE(1), .TIMEOUT(0)) dut1 (
        .clk(clk), .rst(rst), .w_start(ws[1]), .engDone(ed[1]), .wrAck(ack[1]), .abort(ab[1]),
        .wDone(wdone[1]), .busy(busy[1]), .Ldx(ldx[1]), .Ldu(ldu[1]), .engStart(es[1]),
        .shiftL(sh[1]), .wr_req(wr[1]), .err(er[1]), .iterIdx(idx_v[3:2]));
    multi_wrapper_controller #(.ITER(1), .CNT_W(2), .ACK_MODE(0), .TIMEOUT(10)) dut2 (
        .clk(clk), .rst(rst), .w_start(ws[2]), .engDone(ed[2]), .wrAck(ack[2]), .abort(ab[2]),
        .wDone(wdone[2]), .busy(busy[2]), .Ldx(ldx[2]), .Ldu(ldu[2]), .engStart(es[2]),
        .shiftL(sh[2]), .wr_req(wr[2]), .err(er[2]), .iterIdx(idx_v[5:4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_iter(int k);
        return (k == 2) ? 1 : 4;
    endfunction
    function automatic bit m_ack(int k);
        return (k == 1);
    endfunction
    function automatic int m_to(int k);
        return (k == 1) ? 0 : 10;
    endfunction

    function automatic logic [9:0] act(int k);
        return {wdone[k], busy[k], ldx[k], ldu[k], es[k], wr[k], sh[k], er[k], idx_v[2*k +: 2]};
    endfunction

    function automatic logic [9:0] expand(logic [6:0] e);
        return {e[6], e[5], e[4], e[4], e[3], e[2], e[1], e[0], 2'b00};
    endfunction

    function automatic logic [9:0] model_exp(int k);
        logic adv;
        logic w;
        adv = m_ack(k) ? ack[k] : 1'b1;
        w   = (ph[k] == P_WRITE);
        return {ph[k] == P_IDLE,
                (ph[k] == P_INIT) || (ph[k] == P_START) || (ph[k] == P_WAIT) || w,
                ph[k] == P_INIT, ph[k] == P_INIT, ph[k] == P_START, w,
                w && adv && !ab[k], ph[k] == P_ERR, 2'(run[k])};
    endfunction

    task automatic model_update(int k);
        logic adv;
        adv = m_ack(k) ? ack[k] : 1'b1;
        if (ab[k] && ph[k] != P_IDLE) begin
            ph[k] = P_IDLE; run[k] = 0; waited[k] = 0;
        end else begin
            case (ph[k])
                P_IDLE:  if (ws[k]) begin ph[k] = P_INIT; run[k] = 0; end
                P_INIT:  begin run[k] = 0; if (!ws[k]) ph[k] = P_START; end
                P_START: begin waited[k] = 0; ph[k] = P_WAIT; end
                P_WAIT: begin
                    if (ed[k]) ph[k] = P_WRITE;
                    else if (m_to(k) != 0 && waited[k] + 1 == m_to(k)) ph[k] = P_ERR;
                    else waited[k] = waited[k] + 1;
                end
                P_WRITE: if (adv) begin
                    if (run[k] + 1 == m_iter(k)) ph[k] = P_IDLE;
                    else begin run[k] = run[k] + 1; ph[k] = P_START; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ph[k] = P_IDLE; run[k] = 0; waited[k] = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        nchk++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Enter at a falling edge with inputs set; compare, advance model, next falling edge.
    task automatic step();
        #1;
        for (int k = 0; k < 3; k++) begin
            last_obs[k] = act(k);
            chk($sformatf("model_u%0d", k), last_obs[k], model_exp(k));
        end
        for (int k = 0; k < 3; k++) model_update(k);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic w, input logic e, input logic a, input logic [6:0] x, input int n);
        vec_t v;
        v.ws = w; v.ed = e; v.ab = a; v.exp = x;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        int since, es_n, sh_n, wr_n, last_c, wd_c, gap;
        int done;
        logic [1:0] seq[$];

        rst = 1'b0; ws = 3'b000; ed = 3'b000; ack = 3'b000; ab = 3'b000;
        model_reset();

        // ITER=1, TIMEOUT=10: plain job, timeout into ERR, abort, coincident engDone.
        push(1'b0, 1'b0, 1'b0, E_IDLE, 1);
        push(1'b1, 1'b0, 1'b0, E_IDLE, 1);
        push(1'b1, 1'b0, 1'b0, E_INIT, 1);
        push(1'b0, 1'b0, 1'b0, E_INIT, 1);
        push(1'b0, 1'b1, 1'b0, E_START, 1);
        push(1'b0, 1'b0, 1'b0, E_WAIT, 1);
        push(1'b0, 1'b1, 1'b0, E_WAIT, 1);
        push(1'b0, 1'b0, 1'b0, E_WRTS, 1);
        push(1'b1, 1'b0, 1'b0, E_IDLE, 1);
        push(1'b0, 1'b0, 1'b0, E_INIT, 1);
        push(1'b0, 1'b0, 1'b0, E_START, 1);
        push(1'b0, 1'b0, 1'b0, E_WAIT, 10);
        push(1'b1, 1'b0, 1'b0, E_ERR, 2);
        push(1'b0, 1'b0, 1'b1, E_ERR, 1);
        push(1'b1, 1'b0, 1'b0, E_IDLE, 1);
        push(1'b0, 1'b0, 1'b0, E_INIT, 1);
        push(1'b0, 1'b0, 1'b0, E_START, 1);
        push(1'b0, 1'b0, 1'b0, E_WAIT, 9);
        push(1'b0, 1'b1, 1'b0, E_WAIT, 1);
        push(1'b0, 1'b0, 1'b0, E_WRTS, 1);
        push(1'b0, 1'b0, 1'b0, E_IDLE, 1);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("reset_u%0d", k), act(k), RST_PAT);
        rst = 1'b1;
        step();

        foreach (tbl[i]) begin
            ws[2] = tbl[i].ws; ed[2] = tbl[i].ed; ab[2] = tbl[i].ab;
            step();
            chk($sformatf("tbl%0d", i), last_obs[2], expand(tbl[i].exp));
        end
        ws[2] = 1'b0; ed[2] = 1'b0; ab[2] = 1'b0;

        // Four runs, engDone three cycles after each engStart.
        ws[0] = 1'b1; step(); ws[0] = 1'b0;
        since = 0; es_n = 0; sh_n = 0; last_c = -10; wd_c = -1;
        for (int c = 0; c < 80 && wd_c < 0; c++) begin
            ed[0] = (since == 3);
            step();
            if (last_obs[0][5]) begin es_n++; since = 1; end
            else if (since > 0 && since < 3) since++;
            else since = 0;
            if (last_obs[0][3]) begin sh_n++; seq.push_back(last_obs[0][1:0]); last_c = c; end
            if (last_obs[0][9] && sh_n > 0) wd_c = c;
        end
        ed[0] = 1'b0;
        chk_int("run_engstart_count", es_n, 4);
        chk_int("run_shiftl_count", sh_n, 4);
        foreach (seq[i]) chk_int($sformatf("run_idx%0d", i), int'(seq[i]), i);
        chk_int("run_wdone_gap", wd_c - last_c, 1);

        // Acknowledge five cycles into WRITE.
        ws[1] = 1'b1; step(); ws[1] = 1'b0; ed[1] = 1'b1;
        wr_n = 0; sh_n = 0; last_c = -1; gap = -1;
        for (int c = 0; c < 40 && gap < 0; c++) begin
            ack[1] = wr[1] && (wr_n == 4);
            step();
            if (last_obs[1][4]) wr_n++;
            if (last_obs[1][3]) begin sh_n++; last_c = c; end
            if (last_obs[1][5] && sh_n > 0) gap = c - last_c;
        end
        ack[1] = 1'b0; ed[1] = 1'b0;
        chk_int("ack_wr_cycles", wr_n, 5);
        chk_int("ack_shiftl_count", sh_n, 1);
        chk_int("ack_engstart_gap", gap, 1);
        ab[1] = 1'b1; step(); ab[1] = 1'b0; step();

        // Abort coinciding with an accepted write in the second run.
        ws[0] = 1'b1; step(); ws[0] = 1'b0; ed[0] = 1'b1;
        wr_n = 0; done = 0;
        for (int c = 0; c < 40 && done == 0; c++) begin
            if (wr[0]) wr_n++;
            if (wr[0] && wr_n == 2) begin ab[0] = 1'b1; ack[0] = 1'b1; end
            step();
            if (ab[0]) begin
                chk_int("abort_shiftl", int'(last_obs[0][3]), 0);
                done = 1;
            end
        end
        ab[0] = 1'b0; ack[0] = 1'b0; ed[0] = 1'b0;
        chk_int("abort_reached", done, 1);
        chk_int("abort_idle", int'({wdone[0], idx_v[1:0]}), 4);

        // Asynchronous reset while waiting in run 2, then a fresh job.
        ws[0] = 1'b1; step(); ws[0] = 1'b0; ed[0] = 1'b1;
        done = 0;
        for (int c = 0; c < 60 && done == 0; c++) begin
            if (busy[0] && !es[0] && !wr[0] && !ldx[0] && idx_v[1:0] == 2'd2) done = 1;
            else step();
        end
        chk_int("rst_wait_reached", done, 1);
        ed[0] = 1'b0; step(); step();
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("midrst_u%0d", k), act(k), RST_PAT);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        ws[0] = 1'b1; step(); ws[0] = 1'b0;
        chk_int("restart_init_idx", int'({ldx[0], idx_v[1:0]}), 4);
        step(); step();

        // Random traffic on all three variants.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++) begin
                ws[k]  = ($urandom_range(0, 2) == 0);
                ed[k]  = ($urandom_range(0, 3) == 0);
                ack[k] = ($urandom_range(0, 2) == 0);
                ab[k]  = ($urandom_range(0, 15) == 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/multi_wrapper_controller.md
MULTI_WRAPPER_CONTROLLER -- requirements
Module: multi_wrapper_controller

Interface
REQ-001 The block SHALL have the following parameters:
- ITER, default 4: engine runs per job, legal range 1..2^CNT_W.
- CNT_W, default 2: iteration counter width.
- ACK_MODE, default 0: 0 means the write completes in one cycle; 1 means wr_req is held until wrAck.
- TIMEOUT, default 255: maximum WAIT cycles, 0 disables the timeout; TO_W = 8 bits.

REQ-002 The block SHALL have the following ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- w_start  in  1  job request, level.
- engDone  in  1  engine finished the current run.
- wrAck  in  1  writer accepted wr_req; used only when ACK_MODE=1.
- abort  in  1  cancel the job, synchronous.
- wDone  out  1  idle/ready indicator.
- busy  out  1  job in progress.
- Ldx, Ldu  out  1 each  load operand registers.
- engStart  out  1  one-cycle engine start pulse.
- shiftL  out  1  shift result register.
- wr_req  out  1  write request.
- err  out  1  engine timeout flag.
- iterIdx  out  CNT_W  index of the current run.

Function
REQ-003 The FSM SHALL have the states IDLE, INIT, START, WAIT, WRITE and ERR; outputs SHALL be Moore-decoded from the state, except shiftL, which is additionally qualified as in REQ-010.
REQ-004 In IDLE: wDone=1; the FSM SHALL move to INIT when w_start=1.
REQ-005 In INIT: Ldx=Ldu=1 for as long as w_start=1. iter is cleared to 0. The FSM SHALL move to START on the first cycle with w_start=0.
REQ-006 In START: engStart=1 for exactly one cycle; the timeout counter is cleared; the FSM SHALL always move to WAIT. engDone sampled in START SHALL be ignored.
REQ-007 In WAIT, the FSM SHALL move to WRITE when engDone=1; otherwise the timeout counter increments.
REQ-008 In WAIT, if TIMEOUT≠0 and the timeout counter reaches TIMEOUT-1 with engDone=0, the FSM SHALL move to ERR.
REQ-009 engDone and the timeout firing in the same cycle SHALL resolve to WRITE (engDone wins).
REQ-010 Write handshake:
- In WRITE, wr_req=1.
- "advance" = 1 when ACK_MODE=0; "advance" = wrAck when ACK_MODE=1.
- shiftL SHALL equal WRITE & advance & !abort, so it is a single pulse per run.
REQ-011 In WRITE with advance=1: if iter==ITER-1 the FSM SHALL go to IDLE; otherwise iter increments and the FSM goes to START. With advance=0 the FSM SHALL stay in WRITE with wr_req held.
REQ-012 iterIdx SHALL equal iter; iter SHALL never exceed ITER-1 and SHALL never wrap within a job.
REQ-013 In ERR: err=1, wDone=0, busy=0. The FSM SHALL leave ERR only on abort or reset; err SHALL stay asserted until then.
REQ-014 abort=1 in any state other than IDLE SHALL force the FSM to IDLE on the next edge, clear iter and the timeout counter, and suppress shiftL in that cycle; abort has priority over all other transitions.
REQ-015 busy SHALL be 1 in INIT, START, WAIT and WRITE, and 0 otherwise.
REQ-016 A w_start held high across a return to IDLE SHALL start a new job (IDLE→INIT on the next edge).

Reset
REQ-017 rst=0 SHALL asynchronously force state=IDLE, iter=0 and timeout counter=0, and set outputs to wDone=1 with all other outputs 0, including mid-job.
REQ-018 The block SHALL leave reset on the first rising clk edge after rst rises; no output glitch other than the wDone assertion is permitted.

Verification
REQ-019 ITER=4, ACK_MODE=0, engDone returned 3 cycles after each engStart → 4 engStart pulses, 4 shiftL pulses, iterIdx runs 0,1,2,3, wDone=1 one cycle after the 4th WRITE.
REQ-020 ACK_MODE=1, wrAck delayed 5 cycles → wr_req high 5 cycles, shiftL exactly one cycle (the ack cycle), then engStart.
REQ-021 TIMEOUT=10, engDone never arrives → ERR entered 10 cycles after entering WAIT, err=1, held; abort → IDLE, err=0, wDone=1.
REQ-022 abort asserted in WRITE with wrAck=1 at the same edge → no shiftL, IDLE next cycle, iterIdx=0.
REQ-023 rst pulled low in WAIT during iteration 2 → immediate IDLE, all outputs at reset values; a new w_start job restarts at iterIdx=0.
REQ-024 ITER=1 with engDone coincident with the final timeout cycle → WRITE taken, one shiftL, return to IDLE, err=0.
